wb2axis_fifo: RTL and testbench

Buffered Wishbone-to-AXI-Stream bridge. The Wishbone slave accepts one (DW+1)-bit word per write: DW data bits plus a TLAST flag in the MSB. Writes are queued in a DEPTH-entry FIFO, so the Wishbone acknowledge no longer waits for `i_tready`. It sits between a CPU/SoC Wishbone master and an AXI-Stream sink such as a UART or DMA, and replaces the unbuffered single-word bridge where bursts must not stall the bus.

---
 rtl/wb2axis_pkg.sv | 21 ++
 rtl/wb2axis_fifo_mem.sv | 26 ++
 rtl/wb2axis_fifo.sv | 97 +++++++++
 tb/tb_wb2axis_fifo.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb2axis_pkg.sv
// Shared constants for the Wishbone-to-AXI-Stream FIFO bridge: status word layout.
package wb2axis_pkg;

  localparam int unsigned STAT_EMPTY_BIT = 0;
  localparam int unsigned STAT_FULL_BIT  = 1;
  localparam int unsigned STAT_COUNT_LSB = 8;
  localparam int unsigned STAT_COUNT_W   = 8;

  // Packs the FIFO occupancy into the 32-bit status word returned on Wishbone reads.
  function automatic logic [31:0] status_word(input logic [STAT_COUNT_W-1:0] count,
                                              input logic                    full,
                                              input logic                    empty);
    logic [31:0] w;
    w = '0;
    w[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
    w[STAT_FULL_BIT]                  = full;
    w[STAT_EMPTY_BIT]                 = empty;
    return w;
  endfunction

endpackage

// File: rtl/wb2axis_fifo_mem.sv
// Storage array for the bridge FIFO: synchronous write, asynchronous read, no reset.
module wb2axis_fifo_mem #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DW:0]              i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DW:0]              o_rdata
);

  logic [DW:0] mem [DEPTH];

  // Write port: store the pushed word at the write pointer.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  // Read port is combinational so the head word falls through in the push's ack cycle.
  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/wb2axis_fifo.sv
// Buffered Wishbone-to-AXI-Stream bridge. Wishbone writes carry {tlast, tdata} and are
// queued in a DEPTH-entry FIFO whose head drives the AXI-Stream master port.
// Optional feature: define WB2AXIS_FIFO_STATUS_EN to return a status word on reads.
module wb2axis_fifo
  import wb2axis_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [DW:0]   i_wb_dat,
  input  logic          i_wb_we,
  input  logic          i_wb_stb,
  output logic          o_wb_ack,
  output logic [31:0]   o_wb_rdt,
  output logic [DW-1:0] o_tdata,
  output logic          o_tlast,
  output logic          o_tvalid,
  input  logic          i_tready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          ack_q;
  logic          full, empty, push, pop, ack_d;
  logic [DW:0]   head;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // The !ack term stops a held strobe from pushing twice; the master drops stb after ack.
  assign push  = i_wb_stb & i_wb_we & ~ack_q & ~full;
  assign pop   = o_tvalid & i_tready;
  assign ack_d = i_wb_stb & ~ack_q & (~i_wb_we | ~full);

  // Pointer, occupancy and acknowledge state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= ack_d;
      if (push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  wb2axis_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (push),
    .i_waddr (wptr_q),
    .i_wdata (i_wb_dat),
    .i_raddr (rptr_q),
    .o_rdata (head)
  );

  assign o_wb_ack = ack_q;
  assign o_tvalid = ~empty;
  assign o_tdata  = head[DW-1:0];
  assign o_tlast  = head[DW];

`ifdef WB2AXIS_FIFO_STATUS_EN
  logic [31:0] rdt_q;

  // Capture the status word when a read is accepted; it holds until the next read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdt_q <= '0;
    end else if (ack_d && !i_wb_we) begin
      rdt_q <= status_word(STAT_COUNT_W'(count_q), full, empty);
    end
  end

  assign o_wb_rdt = rdt_q;
`else
  assign o_wb_rdt = '0;
`endif

endmodule

// File: tb/tb_wb2axis_fifo.sv
// Self-checking bench for wb2axis_fifo: a fixed vector table, hand-written corner-case
// sequences and randomized traffic compared against a queue-based reference model.
module tb_wb2axis_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [DW:0]   i_wb_dat = '0;
  logic          i_wb_we = 1'b0;
  logic          i_wb_stb = 1'b0;
  logic          o_wb_ack;
  logic [31:0]   o_wb_rdt;
  logic [DW-1:0] o_tdata;
  logic          o_tlast;
  logic          o_tvalid;
  logic          i_tready = 1'b0;

  wb2axis_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_wb_dat (i_wb_dat),
    .i_wb_we  (i_wb_we),
    .i_wb_stb (i_wb_stb),
    .o_wb_ack (o_wb_ack),
    .o_wb_rdt (o_wb_rdt),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .i_tready (i_tready)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue of {tlast, tdata} words plus the ack and read-data registers.
  logic [DW:0] mq[$];
  logic        m_ack = 1'b0;
  logic [31:0] m_rdt = '0;
  logic [DW:0] out_q[$];
  bit          tog_mode = 1'b0;
  bit          tog = 1'b0;

  always @(posedge i_clk or negedge i_rst_n) begin
    bit m_full, m_pop, m_push, m_nack;
    if (!i_rst_n) begin
      mq.delete();
      m_ack = 1'b0;
      m_rdt = '0;
    end else begin
      m_full = (mq.size() == DEPTH);
      m_pop  = (mq.size() != 0) && i_tready;
      m_push = i_wb_stb && i_wb_we && !m_ack && !m_full;
      m_nack = i_wb_stb && !m_ack && (!i_wb_we || !m_full);
`ifdef WB2AXIS_FIFO_STATUS_EN
      if (m_nack && !i_wb_we) begin
        m_rdt = (32'(mq.size()) << 8) | (m_full ? 32'd2 : 32'd0) | ((mq.size() == 0) ? 32'd1 : 32'd0);
      end
`endif
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(i_wb_dat);
      m_ack = m_nack;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    check("model_ack", 32'(o_wb_ack), 32'(m_ack));
    check("model_tvalid", 32'(o_tvalid), (mq.size() != 0) ? 32'd1 : 32'd0);
    if (mq.size() != 0) check("model_head", 32'({o_tlast, o_tdata}), 32'(mq[0]));
    check("model_rdt", o_wb_rdt, m_rdt);
  endtask

  // Apply inputs for one clock edge, log the word popped at that edge, then check.
  task automatic cyc(input logic stb, input logic we, input logic [DW:0] dat, input logic rdy);
    if (tog_mode) begin
      rdy = tog;
      tog = !tog;
    end
    i_wb_stb = stb;
    i_wb_we  = we;
    i_wb_dat = dat;
    i_tready = rdy;
    if (o_tvalid && i_tready) out_q.push_back({o_tlast, o_tdata});
    @(posedge i_clk);
    #1;
    check_model();
  endtask

  // Wishbone write: hold stb until ack (bounded), then release it for one cycle.
  task automatic wb_write(input logic [DW:0] dat, input logic rdy);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc(1'b1, 1'b1, dat, rdy);
      got = o_wb_ack;
    end
    check("wb_write_ack", 32'(got), 32'd1);
    cyc(1'b0, 1'b0, '0, rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && o_tvalid; i++) cyc(1'b0, 1'b0, '0, 1'b1);
    check("drain_empty", 32'(o_tvalid), 32'd0);
  endtask

  typedef struct {
    logic        stb;
    logic        we;
    logic [DW:0] dat;
    logic        rdy;
    logic        ack;
    logic        tv;
    logic [DW:0] head;
  } vec_t;

  vec_t tbl[18];

  initial begin
    // Single write, then fill to full with tready low, stall, and release.
    tbl[0]  = '{1'b1, 1'b1, 9'h155, 1'b0, 1'b1, 1'b1, 9'h155};
    tbl[1]  = '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 9'h000};
    tbl[2]  = '{1'b1, 1'b1, 9'h001, 1'b0, 1'b1, 1'b1, 9'h001};
    tbl[3]  = '{1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 9'h001};
    tbl[4]  = '{1'b1, 1'b1, 9'h002, 1'b0, 1'b1, 1'b1, 9'h001};
    tbl[5]  = '{1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 9'h001};
    tbl[6]  = '{1'b1, 1'b1, 9'h003, 1'b0, 1'b1, 1'b1, 9'h001};
    tbl[7]  = '{1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 9'h001};
    tbl[8]  = '{1'b1, 1'b1, 9'h004, 1'b0, 1'b1, 1'b1, 9'h001};
    tbl[9]  = '{1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 9'h001};
    tbl[10] = '{1'b1, 1'b1, 9'h005, 1'b0, 1'b0, 1'b1, 9'h001};
    tbl[11] = '{1'b1, 1'b1, 9'h005, 1'b0, 1'b0, 1'b1, 9'h001};
    tbl[12] = '{1'b1, 1'b1, 9'h005, 1'b1, 1'b0, 1'b1, 9'h002};
    tbl[13] = '{1'b1, 1'b1, 9'h005, 1'b0, 1'b1, 1'b1, 9'h002};
    tbl[14] = '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 9'h003};
    tbl[15] = '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 9'h004};
    tbl[16] = '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 9'h005};
    tbl[17] = '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 9'h000};

    // Reset state.
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_ack", 32'(o_wb_ack), 32'd0);
    check("reset_tvalid", 32'(o_tvalid), 32'd0);
    check("reset_rdt", o_wb_rdt, 32'd0);
    i_rst_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].stb, tbl[i].we, tbl[i].dat, tbl[i].rdy);
      check($sformatf("vec%0d_ack", i), 32'(o_wb_ack), 32'(tbl[i].ack));
      check($sformatf("vec%0d_tvalid", i), 32'(o_tvalid), 32'(tbl[i].tv));
      if (tbl[i].tv) check($sformatf("vec%0d_head", i), 32'({o_tlast, o_tdata}), 32'(tbl[i].head));
    end

    // Simultaneous push and pop at count 2 keeps the count and the order.
    wb_write(9'h011, 1'b0);
    wb_write(9'h012, 1'b0);
    out_q.delete();
    cyc(1'b1, 1'b1, 9'h013, 1'b1);
    check("pushpop_ack", 32'(o_wb_ack), 32'd1);
    cyc(1'b0, 1'b0, '0, 1'b0);
    check("pushpop_count", 32'(mq.size()), 32'd2);
    drain();
    check("pushpop_nout", 32'(out_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < out_q.size(); i++)
      check($sformatf("pushpop_out%0d", i), 32'(out_q[i]), 32'h11 + 32'(i));

    // Wrap-around: ten writes with tready toggling every cycle.
    out_q.delete();
    tog_mode = 1'b1;
    for (int i = 0; i < 10; i++) wb_write({(i == 9), 8'(8'h30 + i)}, 1'b0);
    tog_mode = 1'b0;
    drain();
    check("wrap_nout", 32'(out_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < out_q.size(); i++)
      check($sformatf("wrap_out%0d", i), 32'(out_q[i]), 32'({(i == 9), 8'(8'h30 + i)}));

    // Asynchronous reset with three words queued and a write strobe in flight.
    wb_write(9'h021, 1'b0);
    wb_write(9'h022, 1'b0);
    wb_write(9'h023, 1'b0);
    i_wb_stb = 1'b1;
    i_wb_we  = 1'b1;
    i_wb_dat = 9'h0AA;
    i_rst_n  = 1'b0;
    #1;
    check("rst_mid_tvalid", 32'(o_tvalid), 32'd0);
    check("rst_mid_ack", 32'(o_wb_ack), 32'd0);
    @(posedge i_clk);
    #1;
    check("rst_hold_ack", 32'(o_wb_ack), 32'd0);
    i_rst_n = 1'b1;
    cyc(1'b1, 1'b1, 9'h0AA, 1'b0);
    check("rst_after_ack", 32'(o_wb_ack), 32'd1);
    check("rst_after_head", 32'({o_tlast, o_tdata}), 32'h0AA);
    cyc(1'b0, 1'b0, '0, 1'b0);
    drain();

    // Status read with three words queued.
    wb_write(9'h031, 1'b0);
    wb_write(9'h032, 1'b0);
    wb_write(9'h033, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
    check("stat_ack", 32'(o_wb_ack), 32'd1);
`ifdef WB2AXIS_FIFO_STATUS_EN
    check("stat_rdt", o_wb_rdt, 32'h0000_0300);
`else
    check("stat_rdt", o_wb_rdt, 32'h0);
`endif
    cyc(1'b0, 1'b0, '0, 1'b1);
`ifdef WB2AXIS_FIFO_STATUS_EN
    check("stat_hold", o_wb_rdt, 32'h0000_0300);
`else
    check("stat_hold", o_wb_rdt, 32'h0);
`endif
    drain();

    // Randomized traffic against the reference model.
    out_q.delete();
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
          (DW + 1)'($urandom), ($urandom_range(0, 2) == 0));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
